// File: rtl/general_register_pkg.sv
// Shared op-code definitions for the general register file and its op unit.
package general_register_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_LOAD = 3'b000;
    localparam logic [OP_W-1:0] OP_INC  = 3'b001;
    localparam logic [OP_W-1:0] OP_DEC  = 3'b010;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b011;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b100;
    localparam logic [OP_W-1:0] OP_CLR  = 3'b101;

endpackage

// File: rtl/general_register_file_if.sv
// Decode-side write/op port and ALU-side read ports of the general register file.
interface general_register_file_if
    import general_register_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ADDR_W = 3
);
    logic              writeEnable;
    logic [ADDR_W-1:0] writeAddr;
    logic [OP_W-1:0]   op;
    logic [WIDTH-1:0]  valueIn;
    logic [ADDR_W-1:0] readAddrA;
    logic [ADDR_W-1:0] readAddrB;
    logic [WIDTH-1:0]  valueOutA;
    logic [WIDTH-1:0]  valueOutB;
    logic              zeroFlag;
    logic              carryFlag;

    modport master (
        output writeEnable, writeAddr, op, valueIn, readAddrA, readAddrB,
        input  valueOutA, valueOutB, zeroFlag, carryFlag
    );

    modport slave (
        input  writeEnable, writeAddr, op, valueIn, readAddrA, readAddrB,
        output valueOutA, valueOutB, zeroFlag, carryFlag
    );
endinterface

// File: rtl/general_register_op_unit.sv
// Combinational read-modify-write operation: result, carry/borrow/shift-out bit, op validity.
module general_register_op_unit
    import general_register_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] old,
    input  logic [WIDTH-1:0] valueIn,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] res,
    output logic             c,
    output logic             opValid
);
    always_comb begin
        res     = old;
        c       = 1'b0;
        opValid = 1'b1;
        case (op)
            OP_LOAD: res = valueIn;
            OP_INC: begin
                res = old + WIDTH'(1);
                c   = &old;
            end
            OP_DEC: begin
                res = old - WIDTH'(1);
                c   = ~|old;
            end
            OP_SHL: begin
                res = {old[WIDTH-2:0], 1'b0};
                c   = old[WIDTH-1];
            end
            OP_SHR: begin
                res = {1'b0, old[WIDTH-1:1]};
                c   = old[0];
            end
            OP_CLR:  res = '0;
            default: opValid = 1'b0;
        endcase
    end
endmodule

// File: rtl/general_register_file.sv
// Parametrised register file: one read-modify-write port, two combinational read ports,
// registered zero/carry flags, optional write-to-read bypass.
module general_register_file
    import general_register_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned ADDR_W    = $clog2(NUM_REGS),
    parameter bit          ZERO_REG0 = 1'b0,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    general_register_file_if.slave  bus
);
    logic [WIDTH-1:0] regs [NUM_REGS];
    logic             zeroQ, carryQ;

    logic             waInRange, raInRange, rbInRange;
    logic [WIDTH-1:0] oldValue, res, storedA, storedB;
    logic             c, opValid, commit;

    // Range checks only exist when the address space has holes above NUM_REGS.
    if (NUM_REGS == (1 << ADDR_W)) begin : g_full
        assign waInRange = 1'b1;
        assign raInRange = 1'b1;
        assign rbInRange = 1'b1;
    end else begin : g_part
        assign waInRange = (32'(bus.writeAddr) < NUM_REGS);
        assign raInRange = (32'(bus.readAddrA) < NUM_REGS);
        assign rbInRange = (32'(bus.readAddrB) < NUM_REGS);
    end

    always_comb begin
        oldValue = '0;
        storedA  = '0;
        storedB  = '0;
        if (waInRange && !(ZERO_REG0 && bus.writeAddr == '0)) oldValue = regs[bus.writeAddr];
        if (raInRange && !(ZERO_REG0 && bus.readAddrA == '0)) storedA = regs[bus.readAddrA];
        if (rbInRange && !(ZERO_REG0 && bus.readAddrB == '0)) storedB = regs[bus.readAddrB];
    end

    general_register_op_unit #(.WIDTH(WIDTH)) u_op (
        .old     (oldValue),
        .valueIn (bus.valueIn),
        .op      (bus.op),
        .res     (res),
        .c       (c),
        .opValid (opValid)
    );

    assign commit = bus.writeEnable && !reset && opValid && waInRange
                    && !(ZERO_REG0 && bus.writeAddr == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            zeroQ  <= 1'b0;
            carryQ <= 1'b0;
        end else if (commit) begin
            regs[bus.writeAddr] <= res;
            zeroQ               <= (res == '0);
            carryQ              <= c;
        end
    end

    always_comb begin
        bus.valueOutA = storedA;
        bus.valueOutB = storedB;
        if (BYPASS && commit && bus.readAddrA == bus.writeAddr) bus.valueOutA = res;
        if (BYPASS && commit && bus.readAddrB == bus.writeAddr) bus.valueOutB = res;
    end

    assign bus.zeroFlag  = zeroQ;
    assign bus.carryFlag = carryQ;
endmodule

// File: tb/tb_general_register_file.sv
// Directed self-checking bench: four parameter variants share one stimulus stream.
module tb_general_register_file;
    import general_register_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       we = 1'b0;
    logic [2:0] wa = '0;
    logic [2:0] opr = '0;
    logic [3:0] vi = '0;
    logic [2:0] ra = '0;
    logic [2:0] rb = '0;
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    general_register_file_if #(.WIDTH(4), .ADDR_W(3)) bus0 ();
    general_register_file_if #(.WIDTH(4), .ADDR_W(3)) bus1 ();
    general_register_file_if #(.WIDTH(4), .ADDR_W(3)) bus2 ();
    general_register_file_if #(.WIDTH(4), .ADDR_W(3)) bus3 ();

    assign {bus0.writeEnable, bus0.writeAddr, bus0.op, bus0.valueIn, bus0.readAddrA, bus0.readAddrB} = {we, wa, opr, vi, ra, rb};
    assign {bus1.writeEnable, bus1.writeAddr, bus1.op, bus1.valueIn, bus1.readAddrA, bus1.readAddrB} = {we, wa, opr, vi, ra, rb};
    assign {bus2.writeEnable, bus2.writeAddr, bus2.op, bus2.valueIn, bus2.readAddrA, bus2.readAddrB} = {we, wa, opr, vi, ra, rb};
    assign {bus3.writeEnable, bus3.writeAddr, bus3.op, bus3.valueIn, bus3.readAddrA, bus3.readAddrB} = {we, wa, opr, vi, ra, rb};

    general_register_file #(.WIDTH(4), .NUM_REGS(8)) u_def (.clock(clock), .reset(reset), .bus(bus0));
    general_register_file #(.WIDTH(4), .NUM_REGS(8), .BYPASS(1'b0)) u_nobyp (.clock(clock), .reset(reset), .bus(bus1));
    general_register_file #(.WIDTH(4), .NUM_REGS(8), .ZERO_REG0(1'b1)) u_zr0 (.clock(clock), .reset(reset), .bus(bus2));
    general_register_file #(.WIDTH(4), .NUM_REGS(6)) u_n6 (.clock(clock), .reset(reset), .bus(bus3));

    task automatic do_op(input logic [2:0] a, input logic [2:0] o, input logic [3:0] v);
        we = 1'b1; wa = a; opr = o; vi = v;
        @(posedge clock); #1;
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        ra = a; rb = a; #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i));
            checks++; if (bus0.valueOutA !== 4'h0) begin errors++; $display("FAIL reset_rdA[%0d] got %h exp 0", i, bus0.valueOutA); end
            checks++; if (bus0.valueOutB !== 4'h0) begin errors++; $display("FAIL reset_rdB[%0d] got %h exp 0", i, bus0.valueOutB); end
        end
        checks++; if ({bus0.zeroFlag, bus0.carryFlag} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {bus0.zeroFlag, bus0.carryFlag}); end
        checks++; if ({bus3.zeroFlag, bus3.carryFlag} !== 2'b00) begin errors++; $display("FAIL reset_flags_n6 got %b exp 00", {bus3.zeroFlag, bus3.carryFlag}); end
    endtask

    task automatic test_load();
        do_op(3'd3, OP_LOAD, 4'hA);
        rd(3'd3);
        checks++; if (bus0.valueOutA !== 4'hA) begin errors++; $display("FAIL load_r3 got %h exp a", bus0.valueOutA); end
        checks++; if ({bus0.zeroFlag, bus0.carryFlag} !== 2'b00) begin errors++; $display("FAIL load_flags got %b exp 00", {bus0.zeroFlag, bus0.carryFlag}); end
        reset = 1'b1;
        do_op(3'd3, OP_LOAD, 4'h5);
        reset = 1'b0;
        rd(3'd3);
        checks++; if (bus0.valueOutA !== 4'h0) begin errors++; $display("FAIL load_under_reset got %h exp 0", bus0.valueOutA); end
    endtask

    task automatic test_inc_wrap();
        do_op(3'd1, OP_LOAD, 4'hF);
        do_op(3'd1, OP_INC, 4'h0);
        rd(3'd1);
        checks++; if (bus0.valueOutA !== 4'h0) begin errors++; $display("FAIL inc_wrap got %h exp 0", bus0.valueOutA); end
        checks++; if ({bus0.zeroFlag, bus0.carryFlag} !== 2'b11) begin errors++; $display("FAIL inc_wrap_flags got %b exp 11", {bus0.zeroFlag, bus0.carryFlag}); end
        do_op(3'd1, OP_INC, 4'h0);
        rd(3'd1);
        checks++; if (bus0.valueOutA !== 4'h1) begin errors++; $display("FAIL inc_again got %h exp 1", bus0.valueOutA); end
        checks++; if ({bus0.zeroFlag, bus0.carryFlag} !== 2'b00) begin errors++; $display("FAIL inc_again_flags got %b exp 00", {bus0.zeroFlag, bus0.carryFlag}); end
    endtask

    task automatic test_dec_shift();
        do_op(3'd2, OP_DEC, 4'h0);
        rd(3'd2);
        checks++; if (bus0.valueOutA !== 4'hF) begin errors++; $display("FAIL dec_borrow got %h exp f", bus0.valueOutA); end
        checks++; if ({bus0.zeroFlag, bus0.carryFlag} !== 2'b01) begin errors++; $display("FAIL dec_borrow_flags got %b exp 01", {bus0.zeroFlag, bus0.carryFlag}); end
        do_op(3'd2, OP_LOAD, 4'h9);
        do_op(3'd2, OP_SHL, 4'h0);
        rd(3'd2);
        checks++; if (bus0.valueOutA !== 4'h2) begin errors++; $display("FAIL shl got %h exp 2", bus0.valueOutA); end
        checks++; if ({bus0.zeroFlag, bus0.carryFlag} !== 2'b01) begin errors++; $display("FAIL shl_flags got %b exp 01", {bus0.zeroFlag, bus0.carryFlag}); end
        do_op(3'd2, OP_SHR, 4'h0);
        rd(3'd2);
        checks++; if (bus0.valueOutA !== 4'h1) begin errors++; $display("FAIL shr got %h exp 1", bus0.valueOutA); end
        checks++; if ({bus0.zeroFlag, bus0.carryFlag} !== 2'b00) begin errors++; $display("FAIL shr_flags got %b exp 00", {bus0.zeroFlag, bus0.carryFlag}); end
    endtask

    task automatic test_bypass();
        do_op(3'd5, OP_LOAD, 4'h6);
        ra = 3'd5; rb = 3'd5;
        we = 1'b1; wa = 3'd5; opr = OP_INC;
        #1;
        checks++; if (bus0.valueOutA !== 4'h7) begin errors++; $display("FAIL byp_A got %h exp 7", bus0.valueOutA); end
        checks++; if (bus0.valueOutB !== 4'h7) begin errors++; $display("FAIL byp_B got %h exp 7", bus0.valueOutB); end
        checks++; if (bus1.valueOutA !== 4'h6) begin errors++; $display("FAIL nobyp_A got %h exp 6", bus1.valueOutA); end
        checks++; if (bus1.valueOutB !== 4'h6) begin errors++; $display("FAIL nobyp_B got %h exp 6", bus1.valueOutB); end
        @(posedge clock); #1;
        we = 1'b0; #1;
        checks++; if (bus0.valueOutA !== 4'h7) begin errors++; $display("FAIL byp_after got %h exp 7", bus0.valueOutA); end
        checks++; if (bus1.valueOutA !== 4'h7) begin errors++; $display("FAIL nobyp_after_A got %h exp 7", bus1.valueOutA); end
        checks++; if (bus1.valueOutB !== 4'h7) begin errors++; $display("FAIL nobyp_after_B got %h exp 7", bus1.valueOutB); end
    endtask

    task automatic test_back_to_back();
        we = 1'b1; wa = 3'd6; opr = OP_INC;
        repeat (3) @(posedge clock);
        #1; we = 1'b0;
        rd(3'd6);
        checks++; if (bus0.valueOutA !== 4'h3) begin errors++; $display("FAIL chain_inc got %h exp 3", bus0.valueOutA); end
    endtask

    task automatic test_suppress();
        do_op(3'd1, OP_LOAD, 4'hF);
        do_op(3'd1, OP_INC, 4'h0);
        do_op(3'd7, OP_LOAD, 4'hC);
        rd(3'd7);
        checks++; if (bus3.valueOutA !== 4'h0) begin errors++; $display("FAIL n6_rd7 got %h exp 0", bus3.valueOutA); end
        checks++; if ({bus3.zeroFlag, bus3.carryFlag} !== 2'b11) begin errors++; $display("FAIL n6_flags got %b exp 11", {bus3.zeroFlag, bus3.carryFlag}); end
        checks++; if (bus0.valueOutA !== 4'hC) begin errors++; $display("FAIL def_rd7 got %h exp c", bus0.valueOutA); end
        rd(3'd5);
        checks++; if (bus3.valueOutA !== 4'h7) begin errors++; $display("FAIL n6_r5_kept got %h exp 7", bus3.valueOutA); end
        do_op(3'd1, OP_LOAD, 4'hF);
        do_op(3'd1, OP_INC, 4'h0);
        do_op(3'd0, OP_LOAD, 4'hC);
        rd(3'd0);
        checks++; if (bus2.valueOutA !== 4'h0) begin errors++; $display("FAIL zr0_rd0 got %h exp 0", bus2.valueOutA); end
        checks++; if ({bus2.zeroFlag, bus2.carryFlag} !== 2'b11) begin errors++; $display("FAIL zr0_flags got %b exp 11", {bus2.zeroFlag, bus2.carryFlag}); end
        checks++; if (bus0.valueOutA !== 4'hC) begin errors++; $display("FAIL def_rd0 got %h exp c", bus0.valueOutA); end
        checks++; if ({bus0.zeroFlag, bus0.carryFlag} !== 2'b00) begin errors++; $display("FAIL def_r0_flags got %b exp 00", {bus0.zeroFlag, bus0.carryFlag}); end
    endtask

    task automatic test_reserved_idle();
        do_op(3'd3, OP_LOAD, 4'hA);
        do_op(3'd1, OP_LOAD, 4'hF);
        do_op(3'd1, OP_INC, 4'h0);
        ra = 3'd3; rb = 3'd3;
        we = 1'b1; wa = 3'd3; opr = 3'b110; vi = 4'h0;
        #1;
        checks++; if (bus0.valueOutA !== 4'hA) begin errors++; $display("FAIL rsv_nobyp got %h exp a", bus0.valueOutA); end
        @(posedge clock); #1;
        opr = 3'b111;
        @(posedge clock); #1;
        we = 1'b0; #1;
        checks++; if (bus0.valueOutA !== 4'hA) begin errors++; $display("FAIL rsv_r3 got %h exp a", bus0.valueOutA); end
        checks++; if ({bus0.zeroFlag, bus0.carryFlag} !== 2'b11) begin errors++; $display("FAIL rsv_flags got %b exp 11", {bus0.zeroFlag, bus0.carryFlag}); end
        we = 1'b0; wa = 3'd3; opr = OP_CLR;
        @(posedge clock); #1;
        checks++; if (bus0.valueOutA !== 4'hA) begin errors++; $display("FAIL idle_r3 got %h exp a", bus0.valueOutA); end
        checks++; if ({bus0.zeroFlag, bus0.carryFlag} !== 2'b11) begin errors++; $display("FAIL idle_flags got %b exp 11", {bus0.zeroFlag, bus0.carryFlag}); end
        do_op(3'd3, OP_CLR, 4'h0);
        rd(3'd3);
        checks++; if (bus0.valueOutB !== 4'h0) begin errors++; $display("FAIL clr_r3 got %h exp 0", bus0.valueOutB); end
        checks++; if ({bus0.zeroFlag, bus0.carryFlag} !== 2'b10) begin errors++; $display("FAIL clr_flags got %b exp 10", {bus0.zeroFlag, bus0.carryFlag}); end
    endtask

    initial begin
        @(posedge clock); #1;
        test_reset();
        test_load();
        test_inc_wrap();
        test_dec_shift();
        test_bypass();
        test_back_to_back();
        test_suppress();
        test_reserved_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/general_register_file.md
Name: general_register_file

Overview:
- Parametrised successor to the single 4-bit general register.
- Holds NUM_REGS registers of WIDTH bits. One write port performs a read-modify-write operation (load, increment, decrement, shift, clear). Two independent read ports.
- Registered zero and carry flags.
- Sits in the processor datapath between instruction decode (address and op select) and the ALU operand inputs.

Parameters:
- WIDTH, 4: bits per register.
- NUM_REGS, 8: number of registers (≥2; need not be a power of 2).
- ADDR_W, $clog2(NUM_REGS): address width. Derived; do not override.
- ZERO_REG0, 0: when 1, register 0 reads as 0 and ignores writes.
- BYPASS, 1: when 1, read ports forward the same-cycle write result.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; clears all registers and flags.
- writeEnable  in  1  high = perform op on register writeAddr this cycle.
- writeAddr  in  ADDR_W  destination (and source) register of the op.
- op  in  3  operation select (encoding below).
- valueIn  in  WIDTH  load data (used by LOAD only).
- readAddrA  in  ADDR_W  read port A address.
- readAddrB  in  ADDR_W  read port B address.
- valueOutA  out  WIDTH  combinational read data, port A.
- valueOutB  out  WIDTH  combinational read data, port B.
- zeroFlag  out  1  registered: last committed result == 0.
- carryFlag  out  1  registered: carry/borrow/shifted-out bit of last committed op.

Behaviour:
- Reset: synchronous, active-high. Has priority over writeEnable.
  - Next edge with reset=1: all registers = 0, zeroFlag = 0, carryFlag = 0.
  - Reset asserted mid-sequence discards that cycle's write.
- Op encoding, with old = current value of reg[writeAddr]:
  - 000 LOAD: res = valueIn, c = 0.
  - 001 INC: res = old+1 mod 2^WIDTH, c = (old == all-ones).
  - 010 DEC: res = old-1 mod 2^WIDTH, c = (old == 0), i.e. borrow.
  - 011 SHL: res = {old[WIDTH-2:0], 0}, c = old[WIDTH-1].
  - 100 SHR: res = {0, old[WIDTH-1:1]}, c = old[0].
  - 101 CLR: res = 0, c = 0.
  - 110, 111 reserved: no write, flags unchanged.
- Commit: when writeEnable=1, reset=0, op is valid and the write is not suppressed:
  - at the rising edge, reg[writeAddr] <= res, zeroFlag <= (res == 0), carryFlag <= c.
  - Latency: 1 cycle from edge to visible register and flag state.
- Write suppression (write discarded, flags unchanged):
  - writeAddr ≥ NUM_REGS;
  - ZERO_REG0=1 and writeAddr == 0.
- writeEnable=0: no state change.
- Reads: combinational from the stored array.
  - Read of an address ≥ NUM_REGS returns 0.
  - With ZERO_REG0=1, a read of address 0 returns 0.
- Bypass, BYPASS=1: if a commit is occurring this cycle and readAddrX == writeAddr, valueOutX = res (the new value).
- Bypass, BYPASS=0: valueOutX = old value until the edge.
- Both read ports may address the same register; both return the same value.
- Consecutive ops on the same register chain: each op uses the value committed at the previous edge.
- All arithmetic is unsigned, modulo 2^WIDTH; no saturation.

Decomposition:
- Package general_register_pkg holds:
  - op code localparams: OP_LOAD, OP_INC, OP_DEC, OP_SHL, OP_SHR, OP_CLR;
  - op field width constant OP_W = 3.
- One sub-module, general_register_op_unit:
  - combinational; inputs old, valueIn, op;
  - outputs res, c, opValid.
  - Reused for the bypass path and the commit path so both see an identical result.
- Top level holds the array, flags, write qualification and the read/bypass muxes.

Test Plan (defaults WIDTH=4, NUM_REGS=8, BYPASS=1, ZERO_REG0=0 unless stated):
- Reset/load:
  - Assert reset 1 cycle → all reads 0, flags 0.
  - LOAD r3 = 4'hA → after edge valueOutA(r3) = A, zeroFlag = 0, carryFlag = 0.
  - LOAD with reset=1 in the same cycle → r3 stays 0.
- Increment wrap: LOAD r1 = F, then INC r1 → r1 = 0, zeroFlag = 1, carryFlag = 1. INC again → r1 = 1, zeroFlag = 0, carryFlag = 0.
- Decrement borrow and shifts:
  - DEC r2 from 0 → r2 = F, carry = 1.
  - LOAD r2 = 9, SHL → r2 = 2, carry = 1.
  - SHR → r2 = 1, carry = 0.
- Bypass: r5 = 6, INC r5 with readAddrA = readAddrB = 5 in the same cycle → both outputs show 7 before the edge. Rerun with BYPASS=0 → both show 6 until the edge, then 7.
- Suppression:
  - ZERO_REG0=1: LOAD r0 = C → r0 reads 0, flags unchanged.
  - NUM_REGS=6: LOAD to address 7 → no register changes, read of address 7 = 0.
- Reserved ops and idle:
  - op = 110 with writeEnable=1 → no state change.
  - writeEnable=0 with op = CLR → r3 retains its value.
